if_icache_responder: RTL and testbench

- Memory-side responder for the instruction-fetch port. It serves the fetch stage's read_a/address_a requests with resp_a/rdata_a.
- Implemented as a small direct-mapped, read-only instruction cache.
- On a miss it runs a single-line fill from physical memory over a 128-bit pmem interface.
- Sits between the fetch stage and the memory arbiter/physical memory.

---
 rtl/if_icache_responder.sv | 122 ++++++++++++
 tb/tb_if_icache_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_icache_responder.sv
// Direct-mapped, read-only instruction cache in front of the fetch port.
// Hits are answered combinationally; a miss runs one 128-bit line fill.
module if_icache_responder #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         read_a,
  input  logic [15:0]  address_a,
  output logic         resp_a,
  output logic [15:0]  rdata_a,
  input  logic         flush,
  output logic         pmem_read,
  output logic [15:0]  pmem_address,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 12 - INDEX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_reg, state_next;
  logic [11:0]         fill_line_reg, fill_line_next;
  logic                flush_pending_reg, flush_pending_next;
  logic [NUM_LINES-1:0] valid_reg;

  logic [TAG_W-1:0]    tag_mem  [NUM_LINES];
  logic [127:0]        data_mem [NUM_LINES];

  logic [2:0]          req_offset;
  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  fill_index;
  logic [TAG_W-1:0]    fill_tag;
  logic [127:0]        lookup_line;
  logic                hit;
  logic                fill_done;
  logic                unused_byte_bit;

  assign req_offset      = address_a[3:1];
  assign req_index       = address_a[3+INDEX_W:4];
  assign req_tag         = address_a[15:4+INDEX_W];
  assign fill_index      = fill_line_reg[INDEX_W-1:0];
  assign fill_tag        = fill_line_reg[11:INDEX_W];
  assign unused_byte_bit = address_a[0];

  assign lookup_line = data_mem[req_index];
  assign hit         = read_a & valid_reg[req_index] & (tag_mem[req_index] == req_tag);
  assign fill_done   = (state_reg == FILL) & pmem_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      fill_line_reg     <= '0;
      flush_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      fill_line_reg     <= fill_line_next;
      flush_pending_reg <= flush_pending_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    fill_line_next     = fill_line_reg;
    flush_pending_next = flush_pending_reg;
    resp_a             = 1'b0;
    rdata_a            = '0;
    pmem_read          = 1'b0;
    pmem_address       = {fill_line_reg, 4'b0000};
    case (state_reg)
      IDLE: begin
        flush_pending_next = 1'b0;
        if (hit) begin
          resp_a  = 1'b1;
          rdata_a = lookup_line[{req_offset, 4'b0000} +: 16];
        end else if (read_a) begin
          fill_line_next = address_a[15:4];
          state_next     = FILL;
        end
      end
      FILL: begin
        // Lookups are blocked for the whole fill, even for resident lines.
        pmem_read = 1'b1;
        if (flush) flush_pending_next = 1'b1;
        if (pmem_resp) begin
          state_next         = IDLE;
          flush_pending_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A flush seen at any point during the fill keeps the new line invalid.
  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      localparam logic [INDEX_W-1:0] LINE_ID = INDEX_W'(gi);
      logic valid_bit_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_bit_reg <= 1'b0;
        end else if (flush) begin
          valid_bit_reg <= 1'b0;
        end else if (fill_done && (fill_index == LINE_ID) && !flush_pending_reg) begin
          valid_bit_reg <= 1'b1;
        end
      end
      assign valid_reg[gi] = valid_bit_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_if_icache_responder.sv
// Directed, table-driven bench for if_icache_responder: one row per cycle,
// plus a hand-written asynchronous reset sequence during a fill.
module tb_if_icache_responder;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic        fl;
    logic        presp;
    logic        e_resp;
    logic [15:0] e_rdata;
    logic        e_pr;
    logic [15:0] e_pa;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         read_a;
  logic [15:0]  address_a;
  logic         resp_a;
  logic [15:0]  rdata_a;
  logic         flush;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  int tests  = 0;
  int failed = 0;
  vec_t vecs[$];

  if_icache_responder #(.NUM_LINES(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .read_a       (read_a),
    .address_a    (address_a),
    .resp_a       (resp_a),
    .rdata_a      (rdata_a),
    .flush        (flush),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  // Memory image: word k of the line at A is {A[15:4],4'h0} | k.
  function automatic logic [127:0] line_for(logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = {a[15:4], 4'h0} | 16'(k);
    return l;
  endfunction

  function automatic vec_t mk(logic rd, logic [15:0] addr, logic fl, logic presp,
                              logic e_resp, logic [15:0] e_rdata, logic e_pr, logic [15:0] e_pa);
    vec_t v;
    v.rd = rd; v.addr = addr; v.fl = fl; v.presp = presp;
    v.e_resp = e_resp; v.e_rdata = e_rdata; v.e_pr = e_pr; v.e_pa = e_pa;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    read_a     = v.rd;
    address_a  = v.addr;
    flush      = v.fl;
    pmem_resp  = v.presp;
    pmem_rdata = line_for(v.e_pa);
    #1;
    $display("[TB] %s rd=%0b addr=%h fl=%0b presp=%0b -> resp=%0b rdata=%h pmem_read=%0b pmem_addr=%h",
             tag, v.rd, v.addr, v.fl, v.presp, resp_a, rdata_a, pmem_read, pmem_address);
    check({tag, " resp_a"}, 16'(resp_a), 16'(v.e_resp));
    check({tag, " pmem_read"}, 16'(pmem_read), 16'(v.e_pr));
    if (v.e_resp || (!v.rd && !v.e_pr)) check({tag, " rdata_a"}, rdata_a, v.e_rdata);
    if (v.e_pr) check({tag, " pmem_address"}, pmem_address, v.e_pa);
  endtask

  initial begin
    // initial fill of line 0 with 3-cycle pmem latency, then hit streak
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h000E, 0, 0, 1, 16'h0007, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0002, 0, 0, 1, 16'h0001, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0004, 0, 0, 1, 16'h0002, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0006, 0, 0, 1, 16'h0003, 0, 16'h0000));
    // conflict on index 0
    vecs.push_back(mk(1, 16'h0080, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0080, 0, 1, 0, 16'h0000, 1, 16'h0080));
    vecs.push_back(mk(1, 16'h0086, 0, 0, 1, 16'h0083, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 16'h000A, 0, 0, 1, 16'h0005, 0, 16'h0000));
    // address changes to a resident line mid-fill
    vecs.push_back(mk(1, 16'h1230, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h1230));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h1230));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h1230));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h1236, 0, 0, 1, 16'h1233, 0, 16'h0000));
    // stray pmem_resp in IDLE is ignored
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h1234, 0, 0, 1, 16'h1232, 0, 16'h0000));
    // flush in IDLE: same-cycle hit still served, then everything misses
    vecs.push_back(mk(1, 16'h0002, 1, 0, 1, 16'h0001, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h1234, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h1230));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
    // flush during fill of 0x0040 leaves the line invalid
    vecs.push_back(mk(1, 16'h0040, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0040, 1, 0, 0, 16'h0000, 1, 16'h0040));
    vecs.push_back(mk(1, 16'h0040, 0, 1, 0, 16'h0000, 1, 16'h0040));
    vecs.push_back(mk(1, 16'h0040, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0040, 0, 1, 0, 16'h0000, 1, 16'h0040));
    vecs.push_back(mk(1, 16'h0046, 0, 0, 1, 16'h0043, 0, 16'h0000));
    // simultaneous pmem_resp and flush
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000));

    // reset state
    reset_n    = 1'b0;
    read_a     = 1'b1;
    address_a  = 16'h0000;
    flush      = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset resp_a", 16'(resp_a), 16'h0);
    check("reset rdata_a", rdata_a, 16'h0000);
    check("reset pmem_read", 16'(pmem_read), 16'h0);
    read_a = 1'b0;
    #1 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset in the middle of a fill
    apply(mk(1, 16'h0050, 0, 0, 0, 16'h0000, 0, 16'h0000), "arst_miss");
    apply(mk(1, 16'h0050, 0, 0, 0, 16'h0000, 1, 16'h0050), "arst_fill");
    #2 reset_n = 1'b0;
    #1;
    $display("[TB] arst asserted -> resp=%0b pmem_read=%0b", resp_a, pmem_read);
    check("arst pmem_read", 16'(pmem_read), 16'h0);
    check("arst resp_a", 16'(resp_a), 16'h0);
    address_a = 16'h0000;
    #1;
    check("arst cached resp_a", 16'(resp_a), 16'h0);
    read_a = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    apply(mk(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000), "post_arst_miss");
    apply(mk(1, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0000), "post_arst_fill");
    apply(mk(1, 16'h0004, 0, 0, 1, 16'h0002, 0, 16'h0000), "post_arst_hit");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
